// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: frame-paced step sequencer, next-head calc and req/ack hand-off.
// Optional build macro SNAKE_WRAP_EN: grid edges wrap instead of killing the snake.
module snake_step_ctrl #(
  parameter int GRID_X          = 16,
  parameter int GRID_Y          = 12,
  parameter int XW              = 4,
  parameter int YW              = 4,
  parameter int FRAMES_PER_STEP = 8,
  parameter int START_X         = 8,
  parameter int START_Y         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic [2:0]    direction,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic          upd_req,
  output logic [XW-1:0] upd_x,
  output logic [YW-1:0] upd_y,
  input  logic          upd_ack,
  output logic          dead
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_CALC,
    S_REQ,
    S_DEAD
  } state_t;

  localparam int CW = $clog2(FRAMES_PER_STEP + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);

  localparam logic [2:0] D_LEFT  = 3'd1;
  localparam logic [2:0] D_RIGHT = 3'd2;
  localparam logic [2:0] D_UP    = 3'd3;
  localparam logic [2:0] D_DOWN  = 3'd4;

  localparam logic signed [XW:0] X_ZERO = '0;
  localparam logic signed [XW:0] X_ONE  = (XW+1)'(1);
  localparam logic signed [XW:0] X_MAX  = (XW+1)'(GRID_X - 1);
  localparam logic signed [YW:0] Y_ZERO = '0;
  localparam logic signed [YW:0] Y_ONE  = (YW+1)'(1);
  localparam logic signed [YW:0] Y_MAX  = (YW+1)'(GRID_Y - 1);

  localparam logic [XW-1:0] X_RST = XW'(START_X);
  localparam logic [YW-1:0] Y_RST = YW'(START_Y);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    step_dir_q, step_dir_d;
  logic [XW-1:0] head_x_q, head_x_d;
  logic [YW-1:0] head_y_q, head_y_d;
  logic [XW-1:0] upd_x_q, upd_x_d;
  logic [YW-1:0] upd_y_q, upd_y_d;

  logic                 is_move;
  logic signed [XW:0]   nx;
  logic signed [YW:0]   ny;
  logic                 off_grid;
  logic [XW-1:0]        nxt_x;
  logic [YW-1:0]        nxt_y;

  assign is_move = (direction >= D_LEFT) && (direction <= D_DOWN);

  // Candidate head from the latched step direction, range-checked one bit wider.
  always_comb begin
    nx = $signed({1'b0, head_x_q});
    ny = $signed({1'b0, head_y_q});
    unique case (1'b1)
      (step_dir_q == D_LEFT):  nx = nx - X_ONE;
      (step_dir_q == D_RIGHT): nx = nx + X_ONE;
      (step_dir_q == D_UP):    ny = ny - Y_ONE;
      (step_dir_q == D_DOWN):  ny = ny + Y_ONE;
      default: ;
    endcase
`ifdef SNAKE_WRAP_EN
    off_grid = 1'b0;
    if (nx < X_ZERO) begin
      nxt_x = XW'(GRID_X - 1);
    end else if (nx > X_MAX) begin
      nxt_x = '0;
    end else begin
      nxt_x = nx[XW-1:0];
    end
    if (ny < Y_ZERO) begin
      nxt_y = YW'(GRID_Y - 1);
    end else if (ny > Y_MAX) begin
      nxt_y = '0;
    end else begin
      nxt_y = ny[YW-1:0];
    end
`else
    off_grid = (nx < X_ZERO) || (nx > X_MAX) ||
               (ny < Y_ZERO) || (ny > Y_MAX);
    nxt_x = nx[XW-1:0];
    nxt_y = ny[YW-1:0];
`endif
  end

  // Next-state, frame counting and handshake bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_dir_d = step_dir_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    upd_x_d    = upd_x_q;
    upd_y_d    = upd_y_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_move) begin
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!is_move) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (sync) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            step_dir_d = direction;
            state_d    = S_CALC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CALC: begin
        if (off_grid) begin
          state_d = S_DEAD;
        end else begin
          upd_x_d = nxt_x;
          upd_y_d = nxt_y;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (upd_ack) begin
          head_x_d = upd_x_q;
          head_y_d = upd_y_q;
          state_d  = S_COUNT;
        end
      end
      S_DEAD: ;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_dir_q <= '0;
      head_x_q   <= X_RST;
      head_y_q   <= Y_RST;
      upd_x_q    <= X_RST;
      upd_y_q    <= Y_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_dir_q <= step_dir_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      upd_x_q    <= upd_x_d;
      upd_y_q    <= upd_y_d;
    end
  end

  assign head_x  = head_x_q;
  assign head_y  = head_y_q;
  assign upd_x   = upd_x_q;
  assign upd_y   = upd_y_q;
  assign upd_req = (state_q == S_REQ);
`ifdef SNAKE_WRAP_EN
  assign dead = 1'b0;
`else
  assign dead = (state_q == S_DEAD);
`endif

endmodule
